// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder (with full_adder_str cell)
// Brief    : Bit-serial N-bit adder. A single full-adder cell is reused across
//            N cycles. A carry flip-flop closes the loop between cycles, and
//            the operands are shifted in LSB-first. Uses a start/busy/done
//            handshake.
// Revision : 1.0 - initial release
// ============================================================================

module full_adder_str (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic w_axb;
    logic w_ab;
    logic w_cx;

    xor u_x1 (w_axb, a, b);
    xor u_x2 (s, w_axb, cin);
    and u_a1 (w_ab, a, b);
    and u_a2 (w_cx, w_axb, cin);
    or  u_o1 (cout, w_ab, w_cx);
endmodule

module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int              CW   = $clog2(N + 1);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_acc;
    logic          r_carry;
    logic [CW-1:0] r_cnt;

    logic          w_fa_s;
    logic          w_fa_cout;
    logic [N-1:0]  w_acc_next;

    full_adder_str u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    // New sum bit enters at the MSB so the LSB lands in bit 0 after N shifts.
    assign w_acc_next = (r_acc >> 1) | (N'(w_fa_s) << (N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_fa_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        sum     <= w_acc_next;
                        cout    <= w_fa_cout;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Scoreboard bench for serial_adder. Exercises an N=8 instance and
//            an N=1 instance side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
    logic [0:0] a1 = '0, b1 = '0, sum1;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted start on the N=8 instance and records the expected result.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        q8.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cv});
        tick();
        start8 = 1'b0;
    endtask

    // Waits (bounded) for done on the N=8 instance, counting busy cycles.
    task automatic wait_done8(output int cyc, output int nb);
        cyc = 0; nb = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 === 1'b1) nb++;
            tick();
            cyc++;
        end
        if (cyc >= 40) begin
            n_cmp++; n_err++;
            $display("FAIL done8_timeout: no done within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_bits;
        rst = 1'b1;
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1;
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        tick(); tick();
        n_cmp++; if ({busy8, done8, cout8} !== 3'b000) begin n_err++;
            $display("FAIL reset_ctl8: got %b want 000", {busy8, done8, cout8}); end
        n_cmp++; if (sum8 !== 8'h00) begin n_err++;
            $display("FAIL reset_sum8: got %h want 00", sum8); end
        n_cmp++; if ({busy1, done1, cout1, sum1} !== 4'b0000) begin n_err++;
            $display("FAIL reset_all1: got %b want 0000", {busy1, done1, cout1, sum1}); end
        start8 = 1'b0; start1 = 1'b0;
        rst = 1'b0;
        tick();
        exp_bits = 8'h00;
        n_cmp++; if ({busy8, done8} !== 2'b00 || sum8 !== exp_bits) begin n_err++;
            $display("FAIL reset_release8: busy=%b done=%b sum=%h want 0 0 00", busy8, done8, sum8); end
    endtask

    task automatic test_carry_ripple();
        int cyc, nb;
        logic [8:0] e;
        issue8(8'hFF, 8'h01, 1'b0);
        wait_done8(cyc, nb);
        e = q8.pop_front();
        n_cmp++; if (nb !== 8) begin n_err++;
            $display("FAIL ripple_busy: got %0d cycles want 8", nb); end
        n_cmp++; if (cyc !== 8) begin n_err++;
            $display("FAIL ripple_latency: got %0d want 8", cyc); end
        n_cmp++; if ({cout8, sum8} !== e || e !== 9'h100) begin n_err++;
            $display("FAIL ripple_result: got %h want %h", {cout8, sum8}, 9'h100); end
        tick();
        n_cmp++; if (done8 !== 1'b0) begin n_err++;
            $display("FAIL ripple_done_width: done=%b want 0", done8); end
    endtask

    task automatic test_carry_in();
        int cyc;
        logic [8:0] e;
        issue8(8'h5A, 8'h3C, 1'b1);
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            n_cmp++; if (sum8 !== 8'h00 || cout8 !== 1'b1) begin n_err++;
                $display("FAIL cin_hold: got %b_%h want 1_00", cout8, sum8); end
            tick();
            cyc++;
        end
        e = q8.pop_front();
        n_cmp++; if (cyc !== 8) begin n_err++;
            $display("FAIL cin_latency: got %0d want 8", cyc); end
        n_cmp++; if ({cout8, sum8} !== e || e !== 9'h097) begin n_err++;
            $display("FAIL cin_result: got %h want 097", {cout8, sum8}); end
        tick();
    endtask

    task automatic test_ignore_start();
        int cyc, nb;
        logic [8:0] e;
        issue8(8'h10, 8'h20, 1'b0);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0;
        wait_done8(cyc, nb);
        e = q8.pop_front();
        n_cmp++; if ({cout8, sum8} !== e || e !== 9'h030) begin n_err++;
            $display("FAIL ignore_first: got %h want 030", {cout8, sum8}); end
        n_cmp++; if (cyc !== 8) begin n_err++;
            $display("FAIL ignore_latency: got %0d want 8", cyc); end
        tick();
        n_cmp++; if (busy8 !== 1'b0) begin n_err++;
            $display("FAIL ignore_e9_busy: got %b want 0", busy8); end
        q8.push_back(9'h1FE);
        tick();
        start8 = 1'b0;
        n_cmp++; if (busy8 !== 1'b1) begin n_err++;
            $display("FAIL ignore_e10_accept: busy=%b want 1", busy8); end
        wait_done8(cyc, nb);
        e = q8.pop_front();
        n_cmp++; if ({cout8, sum8} !== e) begin n_err++;
            $display("FAIL ignore_second: got %h want %h", {cout8, sum8}, e); end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc, nb, ndone;
        logic [8:0] e;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({busy8, done8, cout8, sum8} !== 11'd0) begin n_err++;
            $display("FAIL midrst_outputs: got %b_%b_%b_%h want all 0", busy8, done8, cout8, sum8); end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1) ndone++;
            tick();
        end
        n_cmp++; if (ndone !== 0) begin n_err++;
            $display("FAIL midrst_no_done: got %0d pulses want 0", ndone); end
        issue8(8'h01, 8'h01, 1'b0);
        wait_done8(cyc, nb);
        e = q8.pop_front();
        n_cmp++; if ({cout8, sum8} !== e || e !== 9'h002) begin n_err++;
            $display("FAIL midrst_after: got %h want 002", {cout8, sum8}); end
        tick();
    endtask

    task automatic test_back_to_back8();
        int cyc, nb;
        logic [8:0] e;
        for (int k = 0; k < 1000; k++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            wait_done8(cyc, nb);
            e = q8.pop_front();
            n_cmp++; if ({cout8, sum8} !== e) begin n_err++;
                $display("FAIL b2b8_result[%0d]: got %h want %h", k, {cout8, sum8}, e); end
            n_cmp++; if (nb !== 8 || cyc !== 8) begin n_err++;
                $display("FAIL b2b8_timing[%0d]: busy=%0d lat=%0d want 8/8", k, nb, cyc); end
            tick();
            n_cmp++; if (done8 !== 1'b0) begin n_err++;
                $display("FAIL b2b8_done_width[%0d]: done=%b want 0", k, done8); end
        end
    endtask

    task automatic test_back_to_back1();
        int cyc, nb;
        logic [1:0] e;
        for (int k = 0; k < 1000; k++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); start1 = 1'b1;
            q1.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
            tick();
            start1 = 1'b0;
            cyc = 0; nb = 0;
            while (done1 !== 1'b1 && cyc < 10) begin
                if (busy1 === 1'b1) nb++;
                tick();
                cyc++;
            end
            e = q1.pop_front();
            n_cmp++; if ({cout1, sum1} !== e) begin n_err++;
                $display("FAIL b2b1_result[%0d]: got %b want %b", k, {cout1, sum1}, e); end
            n_cmp++; if (nb !== 1 || cyc !== 1) begin n_err++;
                $display("FAIL b2b1_timing[%0d]: busy=%0d lat=%0d want 1/1", k, nb, cyc); end
            tick();
            n_cmp++; if (done1 !== 1'b0) begin n_err++;
                $display("FAIL b2b1_done_width[%0d]: done=%b want 0", k, done1); end
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_carry_in();
        test_ignore_start();
        test_reset_mid();
        fork
            test_back_to_back8();
            test_back_to_back1();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single instance of the team's structural full adder, `full_adder_str`.
- A carry flip-flop closes the loop, and two operand shift registers feed the adder LSB-first.
- It is the sequential consumer stage of the full adder: it trades N cycles of latency for one adder cell.
- Used in the course datapath as the reference multi-cycle unit with a start/busy/done handshake.

Parameters:
- N, 8, operand and sum width in bits; legal values N >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  N  operand A; captured on the accepting edge only
- b  input  N  operand B; captured on the accepting edge only
- cin  input  1  carry-in; captured on the accepting edge only
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result is valid from this cycle
- sum  output  N  registered result; holds its value until the next completion
- cout  output  1  registered final carry-out; holds with sum

Behaviour:
- Reset (rst=1 at a rising edge, overrides everything):
  - state <= IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry FF and bit counter cleared.
- Reset mid-RUN aborts the operation: no done pulse, outputs zeroed.
- States: IDLE, RUN, DONE. State and all outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - start=1 at edge E0: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, acc<=0, state<=RUN.
  - start=0: stay in IDLE.
- RUN, edges E1..EN, one bit per edge:
  - full_adder_str inputs: a_sh[0], b_sh[0], carry.
  - acc <= {fa_s, acc[N-1:1]} (sum bit shifted in at the MSB, LSB-first fill).
  - a_sh and b_sh shift right, 0 filled in.
  - carry <= fa_cout.
  - cnt increments.
  - At EN (cnt == N-1 before the edge):
    - sum <= {fa_s, acc[N-1:1]}, cout <= fa_cout.
    - done <= 1, state <= DONE.
- DONE:
  - done high for exactly the cycle between EN and EN+1.
  - At EN+1: state <= IDLE, done <= 0.
- busy = 1 exactly from after E0 until EN, i.e. N cycles.
- Latency: done is visible N edges after the start-accepting edge.
- Minimum issue interval is N+2 cycles: start is accepted again from IDLE at EN+2.
- start while in RUN or DONE is ignored. Operands and cin are not re-sampled.
- Operands may change freely after E0.
- sum and cout keep the previous result throughout RUN. They change only at EN or on reset.
- Arithmetic: {cout, sum} == a + b + cin, computed modulo 2^(N+1), for all inputs.
- cnt width: $clog2(N+1). No wrap-around occurs: cnt is reloaded on every accept.
- N=1: RUN lasts one edge; done appears at E1.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 and random operands -> busy=0, done=0, sum=0, cout=0; start is not accepted while rst=1.
- Carry ripple (N=8): a=8'hFF, b=8'h01, cin=0, start pulse at E0 -> busy high for 8 cycles, done pulse after E8, sum=8'h00, cout=1.
- Carry-in (N=8): a=8'h5A, b=8'h3C, cin=1 -> sum=8'h97, cout=0.
  - During RUN, sum still shows 8'h00 (previous result), then updates to 8'h97 exactly with done.
- Ignore start when not idle:
  - Accept a=8'h10, b=8'h20, cin=0, then hold start=1 with a=8'hFF, b=8'hFF.
  - First result sum=8'h30, cout=0 with done after E8.
  - Next accept occurs at E10; its result is sum=8'hFE, cout=1.
- Reset mid-operation: start a=8'hAA, b=8'h55, assert rst at E4 -> IDLE, outputs 0, no done pulse.
  - New start with a=8'h01, b=8'h01, cin=0 -> sum=8'h02, cout=0.
- Random/scoreboard: 1000 back-to-back operations at the minimum interval, N=8 and N=1 builds -> {cout,sum} == a+b+cin every time; done pulses are exactly one cycle wide; busy is high for N cycles.
